// File: rtl/group_mac_acc_if.sv
// Stream bundle for group_mac_acc: operand beats in, requantised lane results out.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid && ready.
// The source holds its data until that edge, and ready never depends on valid.
interface group_mac_acc_if #(
  parameter int GROUP_NB  = 4,
  parameter int IMG_WIDTH = 16,
  parameter int KER_WIDTH = 16,
  parameter int OUT_WIDTH = 16
);
  logic [GROUP_NB*IMG_WIDTH-1:0] img;
  logic [GROUP_NB*KER_WIDTH-1:0] ker;
  logic                          val;
  logic                          last;
  logic                          rdy;
  logic [GROUP_NB*OUT_WIDTH-1:0] res;
  logic [GROUP_NB-1:0]           res_sat;
  logic                          res_val;
  logic                          res_rdy;

  modport master (
    output img, ker, val, last, res_rdy,
    input  rdy, res, res_sat, res_val
  );

  modport slave (
    input  img, ker, val, last, res_rdy,
    output rdy, res, res_sat, res_val
  );
endinterface

// File: rtl/group_mac_acc.sv
// Lane-parallel signed MAC over last-delimited windows, with round-half-up rescale,
// per-lane saturation and a stall-everything back-pressure scheme.
module group_mac_acc #(
  parameter int GROUP_NB  = 4,
  parameter int IMG_WIDTH = 16,
  parameter int KER_WIDTH = 16,
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 14
) (
  input  logic          clk,
  input  logic          rst,
  group_mac_acc_if.slave bus
);
  localparam int PW  = IMG_WIDTH + KER_WIDTH;
  localparam int AW1 = ACC_WIDTH + 1;
  localparam logic signed [AW1-1:0] RND     = AW1'((AW1'(1) << SHIFT) >> 1);
  localparam logic signed [AW1-1:0] OUT_MAX = AW1'((AW1'(1) << (OUT_WIDTH - 1)) - AW1'(1));
  localparam logic signed [AW1-1:0] OUT_MIN = -OUT_MAX - AW1'(1);

  logic                          en;
  logic [GROUP_NB*IMG_WIDTH-1:0] img1_q, img1_d;
  logic [GROUP_NB*KER_WIDTH-1:0] ker1_q, ker1_d;
  logic                          v1_q, v1_d, last1_q, last1_d;
  logic signed [ACC_WIDTH-1:0]   prod2_q [GROUP_NB];
  logic signed [ACC_WIDTH-1:0]   prod2_d [GROUP_NB];
  logic                          v2_q, v2_d, last2_q, last2_d;
  logic signed [ACC_WIDTH-1:0]   acc3_q [GROUP_NB];
  logic signed [ACC_WIDTH-1:0]   acc3_d [GROUP_NB];
  logic [GROUP_NB-1:0]           first3_q, first3_d;
  logic                          v3_q, v3_d, last3_q, last3_d;
  logic [GROUP_NB*OUT_WIDTH-1:0] res_q, res_d;
  logic [GROUP_NB-1:0]           sat_q, sat_d;
  logic                          res_val_q, res_val_d;

  logic signed [PW-1:0]          mul [GROUP_NB];
  logic signed [AW1-1:0]         t [GROUP_NB];
  logic [GROUP_NB*OUT_WIDTH-1:0] res_new;
  logic [GROUP_NB-1:0]           sat_new;

  // A held result freezes every stage, so nothing in flight is ever dropped.
  assign en          = !(res_val_q && !bus.res_rdy);
  assign bus.rdy     = en;
  assign bus.res     = res_q;
  assign bus.res_sat = sat_q;
  assign bus.res_val = res_val_q;

  always_comb begin
    res_new = '0;
    sat_new = '0;
    for (int i = 0; i < GROUP_NB; i++) begin
      mul[i] = PW'($signed(img1_q[i*IMG_WIDTH +: IMG_WIDTH])) *
               PW'($signed(ker1_q[i*KER_WIDTH +: KER_WIDTH]));
      // One guard bit so adding the rounding constant cannot wrap.
      t[i] = ($signed({acc3_q[i][ACC_WIDTH-1], acc3_q[i]}) + RND) >>> SHIFT;
      if (t[i] > OUT_MAX) begin
        res_new[i*OUT_WIDTH +: OUT_WIDTH] = OUT_MAX[OUT_WIDTH-1:0];
        sat_new[i]                        = 1'b1;
      end else if (t[i] < OUT_MIN) begin
        res_new[i*OUT_WIDTH +: OUT_WIDTH] = OUT_MIN[OUT_WIDTH-1:0];
        sat_new[i]                        = 1'b1;
      end else begin
        res_new[i*OUT_WIDTH +: OUT_WIDTH] = t[i][OUT_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    img1_d    = img1_q;
    ker1_d    = ker1_q;
    v1_d      = v1_q;
    last1_d   = last1_q;
    prod2_d   = prod2_q;
    v2_d      = v2_q;
    last2_d   = last2_q;
    acc3_d    = acc3_q;
    first3_d  = first3_q;
    v3_d      = v3_q;
    last3_d   = last3_q;
    res_d     = res_q;
    sat_d     = sat_q;
    res_val_d = res_val_q;
    if (en) begin
      img1_d  = bus.img;
      ker1_d  = bus.ker;
      v1_d    = bus.val;
      last1_d = bus.last;
      v2_d    = v1_q;
      last2_d = last1_q;
      v3_d    = v2_q;
      last3_d = last2_q;
      for (int i = 0; i < GROUP_NB; i++) begin
        prod2_d[i] = ACC_WIDTH'(mul[i]);
        if (v2_q) begin
          acc3_d[i]   = first3_q[i] ? prod2_q[i] : acc3_q[i] + prod2_q[i];
          first3_d[i] = last2_q;
        end
      end
      res_val_d = v3_q && last3_q;
      if (v3_q && last3_q) begin
        res_d = res_new;
        sat_d = sat_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      img1_q    <= '0;
      ker1_q    <= '0;
      v1_q      <= 1'b0;
      last1_q   <= 1'b0;
      v2_q      <= 1'b0;
      last2_q   <= 1'b0;
      first3_q  <= '1;
      v3_q      <= 1'b0;
      last3_q   <= 1'b0;
      res_q     <= '0;
      sat_q     <= '0;
      res_val_q <= 1'b0;
      for (int i = 0; i < GROUP_NB; i++) begin
        prod2_q[i] <= '0;
        acc3_q[i]  <= '0;
      end
    end else begin
      img1_q    <= img1_d;
      ker1_q    <= ker1_d;
      v1_q      <= v1_d;
      last1_q   <= last1_d;
      v2_q      <= v2_d;
      last2_q   <= last2_d;
      first3_q  <= first3_d;
      v3_q      <= v3_d;
      last3_q   <= last3_d;
      res_q     <= res_d;
      sat_q     <= sat_d;
      res_val_q <= res_val_d;
      for (int i = 0; i < GROUP_NB; i++) begin
        prod2_q[i] <= prod2_d[i];
        acc3_q[i]  <= acc3_d[i];
      end
    end
  end
endmodule

// File: tb/tb_group_mac_acc.sv
// Bench for group_mac_acc: windowed vector table plus latency, gap, stall and reset sequences.
module tb_group_mac_acc;
  localparam int NB = 4;
  localparam int IW = 16;
  localparam int KW = 16;
  localparam int AW = 40;
  localparam int OW = 16;
  localparam int SH = 14;

  typedef struct {
    logic [63:0] img;
    logic [63:0] ker;
    int          nbeats;
    logic [63:0] res;
    logic [3:0]  sat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  group_mac_acc_if #(.GROUP_NB(NB), .IMG_WIDTH(IW), .KER_WIDTH(KW), .OUT_WIDTH(OW)) bus();

  group_mac_acc #(
    .GROUP_NB(NB), .IMG_WIDTH(IW), .KER_WIDTH(KW),
    .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(SH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [67:0] exp_q[$];
  logic [67:0] e;
  longint      macc [NB];
  bit          mfirst;
  bit          hold_v;
  logic [63:0] hold_res;
  logic [3:0]  hold_sat;
  vec_t        tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [16:0] rescale(input longint acc);
    longint t;
    t = (acc + 64'sd8192) >>> 14;
    if (t > 32767)       return {1'b1, 16'h7fff};
    else if (t < -32768) return {1'b1, 16'h8000};
    else                 return {1'b0, t[15:0]};
  endfunction

  // Monitor: reset state, stall stability and scoreboard pops.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      check("reset_res_val", 64'(bus.res_val), 64'd0);
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_res_val", 64'(bus.res_val), 64'd1);
        check("hold_res", bus.res, hold_res);
        check("hold_sat", 64'(bus.res_sat), 64'(hold_sat));
      end
      if (bus.res_val && !bus.res_rdy) begin
        hold_v   = 1'b1;
        hold_res = bus.res;
        hold_sat = bus.res_sat;
        check("stall_rdy", 64'(bus.rdy), 64'd0);
      end else begin
        hold_v = 1'b0;
      end
      if (bus.res_val && bus.res_rdy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_result: got %0h expected no result", bus.res);
        end else begin
          e = exp_q.pop_front();
          check("res", bus.res, e[63:0]);
          check("res_sat", 64'(bus.res_sat), 64'(e[67:64]));
        end
      end
    end
  end

  task automatic send_beat(input logic [63:0] i_img, input logic [63:0] i_ker,
                           input logic i_last, input bit push);
    int          guard;
    longint      p;
    logic [16:0] r;
    logic [63:0] er;
    logic [3:0]  es;
    @(negedge clk);
    bus.img  = i_img;
    bus.ker  = i_ker;
    bus.val  = 1'b1;
    bus.last = i_last;
    #1;
    guard = 0;
    while (!bus.rdy && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!bus.rdy) begin
      n_checks++;
      n_fails++;
      $display("FAIL send_timeout: rdy got 0 expected 1");
      bus.val = 1'b0;
      return;
    end
    @(posedge clk);
    for (int i = 0; i < NB; i++) begin
      p = longint'($signed(i_img[i*16 +: 16])) * longint'($signed(i_ker[i*16 +: 16]));
      macc[i] = mfirst ? p : macc[i] + p;
    end
    mfirst = i_last;
    if (i_last && push) begin
      for (int i = 0; i < NB; i++) begin
        r = rescale(macc[i]);
        er[i*16 +: 16] = r[15:0];
        es[i] = r[16];
      end
      exp_q.push_back({es, er});
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.val  = 1'b0;
    bus.last = 1'b0;
    bus.img  = '0;
    bus.ker  = '0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || bus.res_val) && guard < 200) begin
      @(negedge clk);
      #3;
      guard++;
    end
    check("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    logic [63:0] gi, gk, gi2, gk2, gi3, gk3;

    bus.img = '0; bus.ker = '0; bus.val = 1'b0; bus.last = 1'b0; bus.res_rdy = 1'b1;
    mfirst = 1'b1;
    hold_v = 1'b0;
    for (int i = 0; i < NB; i++) macc[i] = 0;

    tbl[0] = '{img: pk(16384, 0, 0, 0), ker: pk(16384, 0, 0, 0), nbeats: 1,
               res: pk(16384, 0, 0, 0), sat: 4'b0000};
    tbl[1] = '{img: pk(100, 100, 100, 100), ker: pk(200, 200, 200, 200), nbeats: 3,
               res: pk(4, 4, 4, 4), sat: 4'b0000};
    tbl[2] = '{img: pk(0, 0, 0, 0), ker: pk(0, 0, 0, 0), nbeats: 1,
               res: pk(0, 0, 0, 0), sat: 4'b0000};
    tbl[3] = '{img: pk(32767, 32767, 32767, 32767), ker: pk(32767, 32767, 32767, 32767), nbeats: 4,
               res: pk(32767, 32767, 32767, 32767), sat: 4'b1111};
    tbl[4] = '{img: pk(-32768, -32768, -32768, -32768), ker: pk(32767, 32767, 32767, 32767), nbeats: 1,
               res: pk(-32768, -32768, -32768, -32768), sat: 4'b1111};
    tbl[5] = '{img: pk(8192, -8192, 8191, -8193), ker: pk(1, 1, 1, 1), nbeats: 1,
               res: pk(1, 0, 0, -1), sat: 4'b0000};
    tbl[6] = '{img: pk(1000, -1000, 300, -7), ker: pk(1000, 1000, -300, -7), nbeats: 2,
               res: pk(122, -122, -11, 0), sat: 4'b0000};
    tbl[7] = '{img: pk(32767, -32768, 32767, -32768), ker: pk(16384, 16384, 16385, 16385), nbeats: 1,
               res: pk(32767, -32768, 32767, -32768), sat: 4'b1100};

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("reset_res", bus.res, 64'd0);
    check("reset_sat", 64'(bus.res_sat), 64'd0);
    check("reset_rdy", 64'(bus.rdy), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    // Latency: last beat in cycle N, result visible in cycle N+4 for one cycle
    send_beat(pk(16384, 0, 0, 0), pk(16384, 0, 0, 0), 1'b1, 1'b1);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      bus.val  = 1'b0;
      bus.last = 1'b0;
      #2;
      lat++;
      if (bus.res_val) seen = 1'b1;
    end
    check("latency", 64'(lat), 64'd4);
    @(negedge clk);
    #2;
    check("res_val_pulse", 64'(bus.res_val), 64'd0);
    drain();

    // Vector table, windows back to back
    for (int v = 0; v < 8; v++) begin
      for (int b = 0; b < tbl[v].nbeats; b++)
        send_beat(tbl[v].img, tbl[v].ker, (b == tbl[v].nbeats - 1), 1'b0);
      exp_q.push_back({tbl[v].sat, tbl[v].res});
    end
    idle();
    drain();

    // Gaps inside a window, then the same window without gaps
    gi  = pk(3000, -2500, 123, 32767);  gk  = pk(7, 9, -11, -32768);
    gi2 = pk(-4000, 1500, 20000, -3);   gk2 = pk(250, -600, 12000, 9);
    gi3 = pk(-1, -1, -1, -1);           gk3 = pk(5000, -5000, 1, 32767);
    send_beat(gi, gk, 1'b0, 1'b1);
    idle(); idle();
    send_beat(gi2, gk2, 1'b0, 1'b1);
    idle();
    send_beat(gi3, gk3, 1'b1, 1'b1);
    send_beat(gi, gk, 1'b0, 1'b1);
    send_beat(gi2, gk2, 1'b0, 1'b1);
    send_beat(gi3, gk3, 1'b1, 1'b1);
    idle();
    drain();

    // Back-pressure: three 1-beat windows with the sink stalled
    @(negedge clk);
    bus.res_rdy = 1'b0;
    send_beat(pk(20000, -20000, 1234, -32768), pk(3000, 3000, -29000, 32767), 1'b1, 1'b1);
    send_beat(pk(16384, 16384, -16384, 5), pk(2, -3, 4, 7), 1'b1, 1'b1);
    send_beat(pk(-9, 32767, 100, 0), pk(30000, 30000, -200, 0), 1'b1, 1'b1);
    @(negedge clk);
    bus.val = 1'b0;
    @(negedge clk);
    bus.img  = pk(7, 7, 7, 7);
    bus.ker  = pk(7000, 7000, 7000, 7000);
    bus.val  = 1'b1;
    bus.last = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("stall_rdy_main", 64'(bus.rdy), 64'd0);
    check("stall_res_val", 64'(bus.res_val), 64'd1);
    bus.val  = 1'b0;
    bus.last = 1'b0;
    @(negedge clk);
    bus.res_rdy = 1'b1;
    drain();

    // Reset in the middle of an open window
    send_beat(pk(1000, 1000, 1000, 1000), pk(1000, 1000, 1000, 1000), 1'b0, 1'b1);
    send_beat(pk(1000, 1000, 1000, 1000), pk(1000, 1000, 1000, 1000), 1'b0, 1'b1);
    @(negedge clk);
    bus.val = 1'b0;
    rst = 1'b0;
    mfirst = 1'b1;
    for (int i = 0; i < NB; i++) macc[i] = 0;
    @(negedge clk);
    rst = 1'b1;
    send_beat(pk(128, 128, 128, 128), pk(128, 128, 128, 128), 1'b1, 1'b0);
    exp_q.push_back({4'b0000, pk(1, 1, 1, 1)});
    idle();
    drain();

    repeat (5) @(negedge clk);
    #3;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_res_val", 64'(bus.res_val), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/group_mac_acc.md
Name: group_mac_acc

Overview:
- Lane-parallel multiply-accumulate group. It takes a stream of GROUP_NB image/kernel value pairs and accumulates one signed dot-product per lane over a window closed by a `last` beat.
- Each lane's sum is rescaled by a fixed right shift with rounding, saturated to OUT_WIDTH and presented on a valid/ready output.
- Successor to the fixed-latency group MAC stage. It adds explicit accumulation windows, output requantisation, saturation flags and back-pressure.
- Sits between the image/kernel fetch streams and the layer output writer.

Parameters:
- GROUP_NB, 4, number of parallel MAC lanes.
- IMG_WIDTH, 16, signed image operand width per lane.
- KER_WIDTH, 16, signed kernel operand width per lane.
- ACC_WIDTH, 40, signed accumulator width per lane; must be >= IMG_WIDTH+KER_WIDTH.
- OUT_WIDTH, 16, signed result width per lane; must be <= ACC_WIDTH-SHIFT.
- SHIFT, 14, arithmetic right shift applied to the accumulator at output; 0 <= SHIFT < ACC_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- img  in  GROUP_NB*IMG_WIDTH  lane i at [i*IMG_WIDTH +: IMG_WIDTH], signed.
- ker  in  GROUP_NB*KER_WIDTH  lane i at [i*KER_WIDTH +: KER_WIDTH], signed.
- val  in  1  input beat valid.
- last  in  1  qualifies a beat as the final one of its accumulation window.
- rdy  out  1  input ready; a beat is accepted when val && rdy.
- res  out  GROUP_NB*OUT_WIDTH  lane i at [i*OUT_WIDTH +: OUT_WIDTH], signed.
- res_sat  out  GROUP_NB  per-lane flag: res lane i was saturated.
- res_val  out  1  result valid.
- res_rdy  in  1  downstream ready; a result is consumed when res_val && res_rdy.

Behaviour:
- Reset (rst low, asynchronous):
  - All pipeline valid bits, res_val, res and res_sat clear to 0.
  - All accumulators clear to 0; each lane's "first beat" flag is set.
  - The next accepted beat after reset starts a new window.
- Global pipeline enable: en = !(res_val && !res_rdy). rdy = en.
  - All stages advance only when en=1; when en=0 every stage holds its contents.
  - rdy is combinational from res_val/res_rdy only, never from val.
- Pipeline stages:
  - S1 registers img, ker, val&&rdy and last.
  - S2 forms the signed products IMG_WIDTH+KER_WIDTH wide, sign-extended to ACC_WIDTH.
  - S3 accumulates: on a valid beat, acc = first ? product : acc + product. first is then set to last. Invalid beats leave acc unchanged.
  - S4: when S3 holds a valid last beat, the output register loads the rescaled result and res_val=1.
- Latency: a last beat accepted in cycle N gives res_val=1 in cycle N+4, absent stalls. Throughput is one beat per cycle; windows may be 1 beat long, back-to-back.
- Rescale per lane, in S4:
  - t = (acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, computed ACC_WIDTH+1 wide. This is round half up, toward +inf on ties.
  - If t > 2^(OUT_WIDTH-1)-1, res = max and res_sat=1.
  - If t < -2^(OUT_WIDTH-1), res = min and res_sat=1.
  - Otherwise res = t and res_sat=0.
- The accumulator wraps in two's complement on ACC_WIDTH overflow; no detection is performed.
- Output handshake:
  - res, res_sat and res_val stay stable while res_val && !res_rdy.
  - When res_val && res_rdy and no new result is arriving, res_val drops next cycle.
  - If a new result arrives in the same cycle as consumption, it loads directly and res_val stays 1.
- val with last=0 and no prior beat simply opens a window.
- last does not need a preceding non-last beat.
- val=0 cycles inside a window are allowed and add nothing.
- img, ker and last are ignored when val=0 or rdy=0.

Test Plan:
- Single beat, lane0 img=16384, ker=16384, last=1, other lanes 0 -> 4 cycles later res lane0=16384, res_sat=0, other lanes 0, res_val for exactly 1 cycle with res_rdy=1.
- 3-beat window, all lanes img=100, ker=200, last on beat 3 -> acc=60000, res=4 on every lane, a single res_val pulse. An immediate 1-beat window with img=ker=0 follows -> res=0 on the next cycle.
- Saturation: 4 beats of img=32767, ker=32767 -> res=32767, res_sat=1. Single beat img=-32768, ker=32767 -> res=-32768, res_sat=1.
- Back-pressure: windows of 1 beat each with res_rdy=0 -> first result held stable and rdy=0 while held. Raise res_rdy -> remaining results emerge in order with no loss or duplication.
- Gaps: beats with val=0 interleaved inside a window -> same result as the gap-free window.
- Reset mid-window: 2 beats img=ker=1000, rst low for 1 cycle, then 1 beat img=ker=128 with last=1 -> res=1 (16384 rounded), no residue from before reset, res_val=0 throughout reset.
